// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with single outstanding request and 2-entry buffer
//
// Purpose: issues instruction fetch requests to memory one at a time and buffers
// up to two returned {pc, instr} pairs for the decoder. It handles PC redirects,
// including dropping responses to requests that a redirect made stale.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   mem_req_valid/ready/addr       fetch request channel (word-aligned byte address)
//   mem_resp_valid/data            fetch response channel (32-bit instruction)
//   redirect_valid/pc              PC redirect from branch/jump resolution
//   ir_valid/ir/ir_pc/ir_ready     instruction channel to the decoder
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [63:0] ir_pc,
  input  logic        ir_ready
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [63:0] fifo_pc_q [2];
  logic [63:0] fifo_pc_d [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];

  logic        req_hs;
  logic        push;
  logic        pop;
  logic        wr_idx;

  // The request outputs are qualified by rst_n so they read as zero for the whole
  // time reset is held, yet a request is presented in the very first cycle after release.
  assign mem_req_valid = rst_n && (state_q == S_FETCH) && (count_q != 2'd2);
  assign mem_req_addr  = rst_n ? pc_q : 64'd0;

  assign ir_valid = (count_q != 2'd0);
  assign ir       = fifo_instr_q[head_q];
  assign ir_pc    = fifo_pc_q[head_q];

  assign req_hs = mem_req_valid && mem_req_ready;
  assign pop    = ir_valid && ir_ready;
  // A response arriving alongside a redirect belongs to the old path and is dropped.
  assign push   = (state_q == S_WAIT) && mem_resp_valid && !redirect_valid;
  // Pushes only happen with at most one entry held, so tail = head + count fits in one bit.
  assign wr_idx = head_q ^ count_q[0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    head_d       = head_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    case (state_q)
      S_FETCH: begin
        if (req_hs) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          // An accepted request that coincides with a redirect is on the wrong path.
          state_d  = redirect_valid ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_FETCH;
        end else if (redirect_valid) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_resp_valid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_pc & ~64'd3;
      head_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_idx]    = req_pc_q;
        fifo_instr_d[wr_idx] = mem_resp_data;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_FETCH;
      pc_q            <= RESET_PC;
      req_pc_q        <= 64'd0;
      head_q          <= 1'b0;
      count_q         <= 2'd0;
      fifo_pc_q[0]    <= 64'd0;
      fifo_pc_q[1]    <= 64'd0;
      fifo_instr_q[0] <= 32'd0;
      fifo_instr_q[1] <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      head_q       <= head_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ir_valid;
  logic [31:0] ir;
  logic [63:0] ir_pc;
  logic        ir_ready;

  int tests  = 0;
  int failed = 0;

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 64'd0; ir_ready = 1'b1;
    cyc(); cyc();
    tests++; if (mem_req_valid !== 1'b0) begin failed++; $display("FAIL reset_req_valid: got %0h exp 0", mem_req_valid); end
    tests++; if (mem_req_addr !== 64'd0) begin failed++; $display("FAIL reset_req_addr: got %0h exp 0", mem_req_addr); end
    tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL reset_ir_valid: got %0h exp 0", ir_valid); end
    tests++; if (ir !== 32'd0) begin failed++; $display("FAIL reset_ir: got %0h exp 0", ir); end
    tests++; if (ir_pc !== 64'd0) begin failed++; $display("FAIL reset_ir_pc: got %0h exp 0", ir_pc); end
    rst_n = 1'b1;
    #1;
    tests++; if (mem_req_valid !== 1'b1) begin failed++; $display("FAIL release_req_valid: got %0h exp 1", mem_req_valid); end
    tests++; if (mem_req_addr !== 64'd0) begin failed++; $display("FAIL release_req_addr: got %0h exp 0", mem_req_addr); end
  endtask

  // One-cycle memory, decoder always ready: one instruction every two cycles.
  task automatic test_stream();
    for (int k = 0; k < 3; k++) begin
      tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'(4 * k)) begin failed++; $display("FAIL stream_req[%0d]: got v=%0h a=%0h exp v=1 a=%0h", k, mem_req_valid, mem_req_addr, 4 * k); end
      cyc();
      tests++; if (mem_req_valid !== 1'b0 || ir_valid !== 1'b0) begin failed++; $display("FAIL stream_wait[%0d]: got req_v=%0h ir_v=%0h exp 0 0", k, mem_req_valid, ir_valid); end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
      cyc();
      mem_resp_valid = 1'b0;
      tests++; if (ir_valid !== 1'b1 || ir_pc !== 64'(4 * k) || ir !== 32'h13) begin failed++; $display("FAIL stream_ir[%0d]: got v=%0h pc=%0h ir=%0h exp v=1 pc=%0h ir=13", k, ir_valid, ir_pc, ir, 4 * k); end
    end
  endtask

  // Entering with one entry (pc 0x8) held and request 0xC pending.
  task automatic test_backpressure();
    ir_ready = 1'b0;
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_00A0;
    cyc();
    mem_resp_valid = 1'b0;
    tests++; if (mem_req_valid !== 1'b0) begin failed++; $display("FAIL bp_full_req_valid: got %0h exp 0", mem_req_valid); end
    tests++; if (ir_valid !== 1'b1 || ir_pc !== 64'h8) begin failed++; $display("FAIL bp_full_head: got v=%0h pc=%0h exp v=1 pc=8", ir_valid, ir_pc); end
    cyc();
    tests++; if (mem_req_valid !== 1'b0) begin failed++; $display("FAIL bp_hold_req_valid: got %0h exp 0", mem_req_valid); end
    ir_ready = 1'b1;
    cyc();
    ir_ready = 1'b0;
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h10) begin failed++; $display("FAIL bp_resume: got v=%0h a=%0h exp v=1 a=10", mem_req_valid, mem_req_addr); end
    tests++; if (ir_pc !== 64'hC || ir !== 32'hA0) begin failed++; $display("FAIL bp_pop_head: got pc=%0h ir=%0h exp pc=c ir=a0", ir_pc, ir); end
  endtask

  task automatic test_redirect_wait();
    ir_ready = 1'b1;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 64'h1003;
    cyc();
    redirect_valid = 1'b0;
    tests++; if (mem_req_valid !== 1'b0 || ir_valid !== 1'b0) begin failed++; $display("FAIL rw_discard: got req_v=%0h ir_v=%0h exp 0 0", mem_req_valid, ir_valid); end
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    cyc();
    mem_resp_valid = 1'b0;
    tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL rw_dropped: got ir_v=%0h ir=%0h exp ir_v=0", ir_valid, ir); end
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000) begin failed++; $display("FAIL rw_next_req: got v=%0h a=%0h exp v=1 a=1000", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_push_pop_and_flush();
    ir_ready = 1'b0;
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1;
    cyc();
    mem_resp_valid = 1'b0;
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h2; ir_ready = 1'b1;
    cyc();
    mem_resp_valid = 1'b0; ir_ready = 1'b0;
    tests++; if (ir_valid !== 1'b1 || ir_pc !== 64'h1004 || ir !== 32'h2) begin failed++; $display("FAIL pushpop_head: got v=%0h pc=%0h ir=%0h exp v=1 pc=1004 ir=2", ir_valid, ir_pc, ir); end
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h3;
    cyc();
    mem_resp_valid = 1'b0;
    tests++; if (mem_req_valid !== 1'b0 || ir_pc !== 64'h1004) begin failed++; $display("FAIL full_state: got req_v=%0h pc=%0h exp 0 1004", mem_req_valid, ir_pc); end
    redirect_valid = 1'b1; redirect_pc = 64'h2000; mem_resp_valid = 1'b1; mem_resp_data = 32'h4; ir_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0; mem_resp_valid = 1'b0; ir_ready = 1'b0;
    tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL flush_ir_valid: got %0h exp 0", ir_valid); end
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h2000) begin failed++; $display("FAIL flush_next_req: got v=%0h a=%0h exp v=1 a=2000", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_redirect_fetch();
    mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h40;
    cyc();
    redirect_valid = 1'b0;
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h40) begin failed++; $display("FAIL rf_nohs: got v=%0h a=%0h exp v=1 a=40", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h3000;
    cyc();
    redirect_valid = 1'b0;
    tests++; if (mem_req_valid !== 1'b0) begin failed++; $display("FAIL rf_discard: got %0h exp 0", mem_req_valid); end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h40AA;
    cyc();
    mem_resp_valid = 1'b0;
    tests++; if (ir_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h3000) begin failed++; $display("FAIL rf_dropped: got ir_v=%0h req_v=%0h a=%0h exp 0 1 3000", ir_valid, mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
    cyc();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL fetch_resp_ignored: got %0h exp 0", ir_valid); end
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
    cyc();
    mem_resp_valid = 1'b0;
    tests++; if (ir_valid !== 1'b1 || ir_pc !== 64'h3000 || ir !== 32'h55) begin failed++; $display("FAIL rf_after: got v=%0h pc=%0h ir=%0h exp v=1 pc=3000 ir=55", ir_valid, ir_pc, ir); end
    ir_ready = 1'b1;
    cyc();
    ir_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h66; redirect_valid = 1'b1; redirect_pc = 64'h5000;
    cyc();
    mem_resp_valid = 1'b0; redirect_valid = 1'b0;
    tests++; if (ir_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h5000) begin failed++; $display("FAIL rwr_drop: got ir_v=%0h req_v=%0h a=%0h exp 0 1 5000", ir_valid, mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_reset_mid();
    cyc();
    rst_n = 1'b0;
    #1;
    tests++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'd0 || ir_valid !== 1'b0) begin failed++; $display("FAIL async_reset: got v=%0h a=%0h ir_v=%0h exp 0 0 0", mem_req_valid, mem_req_addr, ir_valid); end
    cyc();
    rst_n = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD;
    #1;
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'd0) begin failed++; $display("FAIL mid_release_req: got v=%0h a=%0h exp v=1 a=0", mem_req_valid, mem_req_addr); end
    cyc();
    mem_resp_valid = 1'b0;
    tests++; if (ir_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failed++; $display("FAIL stale_ignored: got ir_v=%0h req_v=%0h exp 0 0", ir_valid, mem_req_valid); end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
    cyc();
    mem_resp_valid = 1'b0;
    tests++; if (ir_valid !== 1'b1 || ir_pc !== 64'd0 || ir !== 32'h77) begin failed++; $display("FAIL mid_fresh: got v=%0h pc=%0h ir=%0h exp v=1 pc=0 ir=77", ir_valid, ir_pc, ir); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_push_pop_and_flush();
    test_redirect_fetch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Parameters
REQ-001 RESET_PC, 64'h0000_0000_0000_0000, address of the first instruction fetched after reset; bits [1:0] are zero.

Interface
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 mem_req_valid  output  1  fetch request valid.
REQ-005 mem_req_ready  input  1  memory accepts the request.
REQ-006 mem_req_addr  output  64  fetch byte address, bits [1:0] always 0.
REQ-007 mem_resp_valid  input  1  response data valid.
REQ-008 mem_resp_data  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  PC redirect from branch/jump resolution.
REQ-010 redirect_pc  input  64  redirect target; bits [1:0] ignored and treated as 0.
REQ-011 ir_valid  output  1  instruction available to the decoder.
REQ-012 ir  output  32  instruction word to the decoder.
REQ-013 ir_pc  output  64  address of ir.
REQ-014 ir_ready  input  1  decoder consumes ir.

Function
REQ-015 The block SHALL hold a fetch PC register, a 2-entry FIFO of {pc, instr}, and a 3-state FSM: FETCH, WAIT, DISCARD.
REQ-016 The block SHALL keep at most one memory request outstanding.
REQ-017 In FETCH, mem_req_valid SHALL be 1 iff FIFO occupancy < 2, and mem_req_addr SHALL equal the fetch PC.
REQ-018 On a FETCH request handshake (mem_req_valid & mem_req_ready), the block SHALL latch req_pc = PC, set PC = PC+4 (64-bit wrap), and go to WAIT.
REQ-019 In WAIT and DISCARD, mem_req_valid SHALL be 0.
REQ-020 In WAIT, mem_resp_valid SHALL push {req_pc, mem_resp_data} into the FIFO and return the FSM to FETCH in the same edge.
REQ-021 Responses SHALL be accepted no earlier than the cycle after the request handshake; mem_resp_valid in FETCH SHALL be ignored.
REQ-022 ir_valid SHALL be (occupancy != 0); ir and ir_pc SHALL be the FIFO head entry.
REQ-023 On ir_valid & ir_ready, the FIFO SHALL pop the head entry.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-025 On redirect_valid, the block SHALL flush the FIFO to empty, overriding any same-cycle push or pop.
REQ-026 On redirect_valid, the block SHALL set PC = {redirect_pc[63:2], 2'b00}.
REQ-027 Redirect in FETCH with no handshake SHALL leave the FSM in FETCH; the next cycle requests the redirect target.
REQ-028 Redirect in FETCH with a same-cycle handshake SHALL move the FSM to DISCARD, because the accepted request is stale.
REQ-029 Redirect in WAIT without mem_resp_valid SHALL move the FSM to DISCARD.
REQ-030 Redirect in WAIT with mem_resp_valid SHALL drop the response and move the FSM to FETCH.
REQ-031 In DISCARD, mem_resp_valid SHALL drop the response without pushing it and move the FSM to FETCH; a redirect in DISCARD SHALL only update PC.
REQ-032 Minimum latency SHALL be: request handshake at cycle N, response at N+1, ir_valid=1 at N+2.
REQ-033 Sustained throughput with ir_ready=1 and a 1-cycle memory SHALL be one instruction per 2 cycles.

Reset
REQ-034 While rst_n=0, mem_req_valid and ir_valid SHALL be 0, and mem_req_addr, ir and ir_pc SHALL be 0.
REQ-035 While rst_n=0, the FSM SHALL be FETCH, the FIFO empty, PC=RESET_PC and req_pc=0.
REQ-036 In the first cycle after rst_n rises, mem_req_valid SHALL be 1 with mem_req_addr=RESET_PC.
REQ-037 Reset asserted mid-transaction SHALL abandon the outstanding request; responses after reset release SHALL be ignored until a new handshake.

Verification
REQ-038 Reset release, ready=1, 1-cycle memory returning 0x00000013 -> mem_req_addr 0x0, then 0x4 with 0x8 pending; ir_pc sequence 0x0, 0x4, 0x8; ir=0x00000013 each.
REQ-039 ir_ready=0 with responses flowing -> occupancy reaches 2, mem_req_valid drops to 0; ir_ready=1 for one cycle -> pop, mem_req_valid returns to 1 the next cycle.
REQ-040 Redirect to 0x1003 while in WAIT, response 0xDEADBEEF two cycles later -> response dropped, next mem_req_addr=0x1000, no ir_valid for 0xDEADBEEF.
REQ-041 Redirect to 0x2000 in the same cycle as a response and a pop with FIFO full -> FIFO empty next cycle, ir_valid=0, next request address 0x2000.
REQ-042 Redirect coincident with a FETCH handshake at 0x40 -> the 0x40 response is discarded, and the next request is issued to the redirect target.
REQ-043 rst_n pulsed low while in WAIT -> all outputs 0 immediately (asynchronous); after release, request to RESET_PC; a stale response in that cycle is ignored.
